// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FAULT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  // Word accesses only: any set bit under this mask is a misaligned request.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters, with a bounded data
// streak so a waiting fetch is never starved.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   grant_en,
  input  logic   if_req,
  input  logic   d_req,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_BURST);

  logic [CNT_W-1:0] streak_q, streak_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_valid = grant_en && (if_req || d_req);
    gnt_owner = (if_req && (!d_req || streak_q == STREAK_MAX)) ? OWN_IF : OWN_D;
    streak_d  = streak_q;

    if (!if_req) begin
      streak_d = '0;
    end else if (gnt_valid && gnt_owner == OWN_IF) begin
      streak_d = '0;
    end else if (gnt_valid && streak_q != STREAK_MAX) begin
      streak_d = streak_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, load/store) in front of a single-port
// memory with one outstanding transaction and misaligned-access faulting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fault
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                arb_valid;
  owner_e              arb_owner;

  mem_arb_prio #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .grant_en (state_q == S_IDLE),
    .if_req   (if_req),
    .d_req    (d_req),
    .gnt_valid(arb_valid),
    .gnt_owner(arb_owner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    fault     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_owner;
          if (arb_owner == OWN_IF) begin
            if_gnt  = 1'b1;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = if_addr;
            wdata_d = '0;
          end else begin
            d_gnt   = 1'b1;
            we_d    = d_we;
            be_d    = d_be;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
          state_d = is_misaligned(addr_d[1:0]) ? S_FAULT : S_ISSUE;
        end
      end

      S_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          if (we_q) begin
            // Stores complete at the handshake; only the data port writes.
            d_rvalid = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            d_rvalid  = 1'b1;
            d_rdata   = mem_rdata;
          end
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        fault = 1'b1;
        if (owner_q == OWN_IF) if_rvalid = 1'b1;
        else                   d_rvalid  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Grants are combinational on the requests, so they must be masked while reset is held.
    if (reset) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      fault     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch read, burst fairness,
// stalled store, misalignment faults and reset during an outstanding read.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fault;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {57'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, fault}, 64'd0);
    check({tag, "_be"}, {60'd0, mem_be}, 64'd0);
    check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] burst_got;
    logic [9:0] burst_exp;
    int         n_gnt;
    int         n_dual;

    reset      = 1'b1;
    if_req     = 1'b1;
    if_addr    = 32'h0000_0100;
    d_req      = 1'b1;
    d_we       = 1'b0;
    d_be       = 4'hF;
    d_addr     = 32'h0000_0400;
    d_wdata    = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // Reset held with both masters requesting: everything stays quiet.
    settle();
    check_quiet("reset");
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b0;
    step();

    // Single fetch: gnt at t0, mem_req at t1, response at t3.
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    mem_ready = 1'b1;
    settle();
    check("fetch_gnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    check("fetch_t0_memreq", {63'd0, mem_req}, 64'd0);
    step();
    if_req = 1'b0;
    settle();
    check("fetch_t1_memreq", {63'd0, mem_req}, 64'd1);
    check("fetch_t1_addr", {32'd0, mem_addr}, 64'h100);
    check("fetch_t1_we_be", {59'd0, mem_we, mem_be}, 64'h0F);
    check("fetch_t1_gnt", {63'd0, if_gnt}, 64'd0);
    step();
    settle();
    check("fetch_t2_rvalid", {63'd0, if_rvalid}, 64'd0);
    check("fetch_t2_memreq", {63'd0, mem_req}, 64'd0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hE3A0_0001;
    settle();
    check("fetch_t3_rvalid", {63'd0, if_rvalid}, 64'd1);
    check("fetch_t3_rdata", {32'd0, if_rdata}, 64'hE3A0_0001);
    check("fetch_t3_d_rvalid", {63'd0, d_rvalid}, 64'd0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check("fetch_t4_rvalid", {63'd0, if_rvalid}, 64'd0);
    check("fetch_t4_rdata", {32'd0, if_rdata}, 64'd0);
    step();

    // Both masters always requesting: four data grants, then one fetch.
    if_req     = 1'b1;
    if_addr    = 32'h0000_0100;
    d_req      = 1'b1;
    d_we       = 1'b0;
    d_be       = 4'hF;
    d_addr     = 32'h0000_0400;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    burst_got  = '0;
    burst_exp  = 10'b10000_10000;
    n_gnt      = 0;
    n_dual     = 0;
    for (int c = 0; c < 80 && n_gnt < 10; c++) begin
      settle();
      if (if_gnt && d_gnt) n_dual++;
      if (if_gnt || d_gnt) begin
        burst_got[n_gnt] = if_gnt;
        n_gnt++;
      end
      step();
    end
    check("burst_count", 64'(n_gnt), 64'd10);
    check("burst_order", {54'd0, burst_got}, {54'd0, burst_exp});
    check("burst_dual_gnt", 64'(n_dual), 64'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    step();
    step();
    step();
    mem_rvalid = 1'b0;
    mem_ready  = 1'b0;

    // Store stalled three cycles: fields hold, completion at the handshake.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h0000_0200;
    d_wdata = 32'hDEAD_BEEF;
    settle();
    check("store_gnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    step();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'h0;
    d_addr  = 32'h0000_0FFC;
    d_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("store_stall_ctl", {61'd0, mem_req, mem_we, d_rvalid}, 64'b110);
      check("store_stall_be", {60'd0, mem_be}, 64'h3);
      check("store_stall_fields", {mem_addr, mem_wdata}, 64'h0000_0200_DEAD_BEEF);
      step();
    end
    mem_ready = 1'b1;
    settle();
    check("store_done_ctl", {62'd0, mem_req, d_rvalid}, 64'b11);
    check("store_done_rdata", {32'd0, d_rdata}, 64'd0);
    step();
    mem_ready = 1'b0;
    settle();
    check("store_after", {62'd0, mem_req, d_rvalid}, 64'd0);
    step();

    // Misaligned load: fault cycle, memory untouched, stray mem_rvalid ignored.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_be   = 4'hF;
    d_addr = 32'h0000_0203;
    settle();
    check("dfault_gnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    check("dfault_t0_fault", {63'd0, fault}, 64'd0);
    step();
    d_req      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA_5555;
    settle();
    check("dfault_t1_ctl", {60'd0, fault, d_rvalid, mem_req, if_rvalid}, 64'b1100);
    check("dfault_t1_rdata", {32'd0, d_rdata}, 64'd0);
    step();
    mem_rvalid = 1'b0;
    settle();
    check("dfault_t2_ctl", {62'd0, fault, d_rvalid}, 64'd0);
    step();

    // Misaligned fetch reports through the fetch port.
    if_req  = 1'b1;
    if_addr = 32'h0000_0102;
    settle();
    check("ifault_gnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    step();
    if_req = 1'b0;
    settle();
    check("ifault_t1_ctl", {60'd0, fault, if_rvalid, d_rvalid, mem_req}, 64'b1100);
    check("ifault_t1_rdata", {32'd0, if_rdata}, 64'd0);
    step();

    // Reset during WAIT: outputs drop at once and the late return is dropped.
    if_req    = 1'b1;
    if_addr   = 32'h0000_0300;
    mem_ready = 1'b1;
    settle();
    check("rstwait_gnt", {63'd0, if_gnt}, 64'd1);
    step();
    if_req = 1'b0;
    settle();
    check("rstwait_issue", {63'd0, mem_req}, 64'd1);
    step();
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check_quiet("rstwait_async");
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      settle();
      check_quiet("rstwait_late");
      step();
    end
    mem_rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
